cache_arbiter: RTL and testbench



---
 rtl/cache_arbiter_pkg.sv | 22 ++
 rtl/cache_arbiter_line_burst_buffer.sv | 48 ++++
 rtl/cache_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the Icache/Dcache memory-port arbiter.
// Provides the package cache_types used by cache_arbiter and line_burst_buffer.
package cache_types;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } arb_req_t;

endpackage

// File: rtl/cache_arbiter_line_burst_buffer.sv
// Line register plus beat counter: serialises a 256-bit line into 64-bit beats
// for writes and assembles incoming beats into the line for reads.
module line_burst_buffer
    import cache_types::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_line,
    input  logic [LINE_W-1:0] load_data,
    input  logic              beat_en,
    input  logic              beat_capture,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [BEAT_W-1:0] beat_out,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    localparam int NB = LINE_W / BEAT_W;
    localparam int CW = $clog2(NB);

    logic [CW-1:0]     beat_cnt;
    logic [LINE_W-1:0] line_q;

    // Counter wraps naturally after the last beat, ready for the next burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            line_q   <= '0;
        end else begin
            if (load_line) begin
                line_q <= load_data;
            end else if (beat_en && beat_capture) begin
                line_q[int'(beat_cnt) * BEAT_W +: BEAT_W] <= beat_in;
            end
            if (beat_en) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign beat_out  = line_q[int'(beat_cnt) * BEAT_W +: BEAT_W];
    assign line      = line_q;
    assign last_beat = (beat_cnt == CW'(NB - 1));

endmodule

// File: rtl/cache_arbiter.sv
// Shares one 64-bit burst memory port between Icache and Dcache line requests.
// Define CACHE_ARB_RR_EN for round-robin tie-breaking; default is fixed Dcache priority.
module cache_arbiter
    import cache_types::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [31:0]       i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [31:0]       d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state, state_nxt;
    arb_req_t          req_q, grant;
    logic [31:0]       addr_q;
    logic              i_req, d_req, tie_to_d;
    logic              grant_en, busy, beat_en, load_line, last_beat;
    logic [LINE_W-1:0] line;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

`ifdef CACHE_ARB_RR_EN
    logic favour_d_q;

    // After serving one cache, the other one wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            favour_d_q <= 1'b1;
        end else if (grant_en) begin
            favour_d_q <= (grant == REQ_I);
        end
    end

    assign tie_to_d = favour_d_q;
`else
    assign tie_to_d = 1'b1;
`endif

    assign grant     = (d_req && (!i_req || tie_to_d)) ? REQ_D : REQ_I;
    assign grant_en  = (state == IDLE) && (i_req || d_req);
    assign busy      = (state == I_RD) || (state == D_RD) || (state == D_WR);
    assign beat_en   = busy && mem_resp;
    assign load_line = grant_en && (grant == REQ_D) && d_mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            req_q  <= REQ_D;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                req_q  <= grant;
                addr_q <= (grant == REQ_I) ? i_mem_address : d_mem_address;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_mem_resp = 1'b0;
        d_mem_resp = 1'b0;
        case (state)
            IDLE: begin
                if (grant_en) begin
                    if (grant == REQ_I)   state_nxt = I_RD;
                    else if (d_mem_write) state_nxt = D_WR;
                    else                  state_nxt = D_RD;
                end
            end
            I_RD, D_RD: begin
                mem_read = 1'b1;
                if (beat_en && last_beat) state_nxt = DONE;
            end
            D_WR: begin
                mem_write = 1'b1;
                if (beat_en && last_beat) state_nxt = DONE;
            end
            DONE: begin
                // Turnaround cycle: requests are ignored while the served cache drops its own.
                i_mem_resp = (req_q == REQ_I);
                d_mem_resp = (req_q == REQ_D);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && state == IDLE) begin
            assert (!(d_mem_read && d_mem_write))
                else $error("cache_arbiter: Dcache read and write raised together");
        end
    end

    line_burst_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .load_line    (load_line),
        .load_data    (d_mem_wdata),
        .beat_en      (beat_en),
        .beat_capture (state != D_WR),
        .beat_in      (mem_rdata),
        .beat_out     (mem_wdata),
        .line         (line),
        .last_beat    (last_beat)
    );

    assign mem_address = addr_q;
    assign i_mem_rdata = line;
    assign d_mem_rdata = line;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares every resp pulse.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_mem_read;
    logic [31:0]   i_mem_address;
    logic [LW-1:0] i_mem_rdata;
    logic          i_mem_resp;
    logic          d_mem_read;
    logic          d_mem_write;
    logic [31:0]   d_mem_address;
    logic [LW-1:0] d_mem_wdata;
    logic [LW-1:0] d_mem_rdata;
    logic          d_mem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata;
    logic          mem_resp;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_mem_read    (i_mem_read),
        .i_mem_address (i_mem_address),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_resp    (i_mem_resp),
        .d_mem_read    (d_mem_read),
        .d_mem_write   (d_mem_write),
        .d_mem_address (d_mem_address),
        .d_mem_wdata   (d_mem_wdata),
        .d_mem_rdata   (d_mem_rdata),
        .d_mem_resp    (d_mem_resp),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_resp      (mem_resp)
    );

    typedef struct packed {
        logic          is_d;
        logic [LW-1:0] line;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_line(input logic [7:0] b);
        logic [LW-1:0] l;
        for (int i = 0; i < 4; i++) l[i*BW +: BW] = {8{b + 8'(i)}};
        return l;
    endfunction

    // Monitor: every resp pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (i_mem_resp || d_mem_resp)) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {i_mem_resp, d_mem_resp}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_i", i_mem_resp, !e.is_d);
                check("resp_d", d_mem_resp, e.is_d);
                check("rdata", e.is_d ? d_mem_rdata : i_mem_rdata, e.line);
                check("mem_req_in_done", {mem_read, mem_write}, '0);
            end
        end
    end

    // Called at posedge+1 with the request already driven; returns at posedge+1
    // just after the resp cycle, so the caller can drop its request there.
    task automatic do_burst(input logic [31:0] exp_addr, input logic is_wr,
                            input logic [LW-1:0] line, input logic [7:0] pat,
                            input int pat_len);
        int waited = 0;
        int k = 0;
        mem_resp = 1'b0;
        @(negedge clk);
        while (!(mem_read || mem_write) && waited < 12) begin
            @(posedge clk); #1;
            waited++;
            @(negedge clk);
        end
        check("req_latency", 32'(waited), 32'd1);
        if (!(mem_read || mem_write)) return;
        for (int i = 0; i < pat_len; i++) begin
            check("mem_read", mem_read, !is_wr);
            check("mem_write", mem_write, is_wr);
            check("mem_address", mem_address, exp_addr);
            if (is_wr) check("mem_wdata", mem_wdata, line[k*BW +: BW]);
            mem_resp  = pat[i];
            mem_rdata = pat[i] ? line[k*BW +: BW] : 64'hDEAD_BEEF_0BAD_F00D;
            @(posedge clk); #1;
            if (pat[i]) k++;
            mem_resp = 1'b0;
            if (i != pat_len - 1) @(negedge clk);
        end
        @(negedge clk);
        check("resp_timing", i_mem_resp | d_mem_resp, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] ln;
        rst = 1'b1;
        i_mem_read = 0; i_mem_address = '0;
        d_mem_read = 0; d_mem_write = 0; d_mem_address = '0; d_mem_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_resp", {i_mem_resp, d_mem_resp}, '0);
        check("rst_rdata", i_mem_rdata, '0);
        check("rst_mem_address", mem_address, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Icache miss alone
        ln = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        sb.push_back({1'b0, ln});
        i_mem_read = 1; i_mem_address = 32'h0000_0060;
        do_burst(32'h60, 1'b0, ln, 8'h0F, 4);
        i_mem_read = 0;
        repeat (2) @(posedge clk); #1;

        // Dcache writeback with stalls
        ln = mk_line(8'hA0);
        sb.push_back({1'b1, ln});
        d_mem_write = 1; d_mem_address = 32'h0000_03E0; d_mem_wdata = ln;
        do_burst(32'h3E0, 1'b1, ln, 8'b0010_1101, 6);
        d_mem_write = 0; d_mem_wdata = '0;
        repeat (2) @(posedge clk); #1;

        // Reset during beat 2 of an Icache fill
        ln = mk_line(8'hC0);
        i_mem_read = 1; i_mem_address = 32'h0000_0080;
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            mem_resp = 1; mem_rdata = ln[b*BW +: BW];
            @(posedge clk); #1;
        end
        mem_resp = 1; mem_rdata = ln[2*BW +: BW];
        rst = 1; i_mem_read = 0;
        @(posedge clk); #1;
        rst = 0; mem_resp = 0;
        @(negedge clk);
        check("abort_mem_read", mem_read, 1'b0);
        check("abort_mem_write", mem_write, 1'b0);
        check("abort_resp", {i_mem_resp, d_mem_resp}, '0);
        check("abort_line_cleared", i_mem_rdata, '0);
        check("abort_mem_wdata", mem_wdata, '0);
        repeat (3) @(posedge clk); #1;
        ln = mk_line(8'h30);
        sb.push_back({1'b1, ln});
        d_mem_read = 1; d_mem_address = 32'h0000_00A0;
        do_burst(32'hA0, 1'b0, ln, 8'h0F, 4);
        d_mem_read = 0;
        repeat (2) @(posedge clk); #1;

        // Simultaneous requests held across four bursts, from a fresh pointer
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        i_mem_read = 1; i_mem_address = 32'h0000_0100;
        d_mem_read = 1; d_mem_address = 32'h0000_0200;
        for (int j = 0; j < 4; j++) begin
            logic win_d;
`ifdef CACHE_ARB_RR_EN
            win_d = (j % 2 == 0);
`else
            win_d = 1'b1;
`endif
            ln = mk_line(8'(8'h50 + 8'(16 * j)));
            sb.push_back({win_d, ln});
            do_burst(win_d ? 32'h200 : 32'h100, 1'b0, ln, 8'h0F, 4);
        end
        i_mem_read = 0; d_mem_read = 0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("idle_mem_read", mem_read, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
